// File: rtl/seq_alu_pkg.sv
`default_nettype none
//==============================================================================
// Module   : seq_alu_pkg
// Desc     : Opcodes, FSM state encoding and ERR bit positions for seq_alu.
// Revision : 1.0 - initial release
//==============================================================================
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_MOD = 4'b0100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int ERR_OVF = 0;
    localparam int ERR_DZ  = 1;

endpackage
`default_nettype wire

// File: rtl/seq_alu_divstep.sv
`default_nettype none
//==============================================================================
// Module   : seq_alu_divstep
// Desc     : One combinational restoring-division step on unsigned magnitudes.
// Revision : 1.0 - initial release
//==============================================================================
module seq_alu_divstep #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_rem,
    input  logic [W-1:0] i_divisor,
    input  logic         i_dvd_bit,
    output logic [W-1:0] o_rem,
    output logic         o_q
);

    logic [W:0]   w_shift;
    logic [W-1:0] w_diff;

    // The incoming remainder is always below the divisor, so the restored
    // value fits in W bits. The difference is only used when it is non-negative.
    assign w_shift = {i_rem, i_dvd_bit};
    assign o_q     = (w_shift >= {1'b0, i_divisor});
    assign w_diff  = w_shift[W-1:0] - i_divisor;
    assign o_rem   = o_q ? w_diff : w_shift[W-1:0];

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
//==============================================================================
// Module   : seq_alu
// Desc     : Multi-cycle signed ALU (add/sub, shift-add multiply, restoring
//            divide/modulo) with START/BUSY/DONE handshake. Optional macro
//            SEQ_ALU_EARLY_TERM_EN ends multiply once the multiplier is spent.
// Revision : 1.0 - initial release
//==============================================================================
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int W  = 16,
    parameter int CW = $clog2(W + 1)
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           START,
    input  logic [3:0]     OP,
    input  logic [W-1:0]   IN1,
    input  logic [W-1:0]   IN2,
    output logic           BUSY,
    output logic           DONE,
    output logic [2*W-1:0] OUT,
    output logic [1:0]     ERR
);

    state_t         r_state;
    state_t         w_state_next;
    logic [3:0]     r_op;
    logic           r_neg;
    logic           r_a_neg;
    logic [CW-1:0]  r_cnt;
    logic [2*W-1:0] r_acc;
    logic [2*W-1:0] r_mcand;
    logic [W-1:0]   r_opb_mag;
    logic [W-1:0]   r_rem;
    logic [W-1:0]   r_dq;
    logic [2*W-1:0] r_out;
    logic [1:0]     r_err;

    logic [W-1:0]   w_a_mag;
    logic [W-1:0]   w_b_mag;
    logic           w_is_iter;
    logic           w_last;
    logic [2*W-1:0] w_acc_next;
    logic [W-1:0]   w_mplier_next;
    logic [W-1:0]   w_div_rem;
    logic           w_q_bit;
    logic [2*W-1:0] w_sc_res;
    logic [1:0]     w_sc_err;
    logic [2*W-1:0] w_fix_res;
    logic [1:0]     w_fix_err;

    function automatic logic [2*W-1:0] sext(input logic [W-1:0] v);
        return {{W{v[W-1]}}, v};
    endfunction

    // True when the upper W+1 bits are not a pure sign extension.
    function automatic logic out_of_range(input logic [2*W-1:0] v);
        return !((&v[2*W-1:W-1]) || !(|v[2*W-1:W-1]));
    endfunction

    assign w_a_mag   = IN1[W-1] ? -IN1 : IN1;
    assign w_b_mag   = IN2[W-1] ? -IN2 : IN2;
    assign w_is_iter = (OP == OP_MUL) ||
                       (((OP == OP_DIV) || (OP == OP_MOD)) && (IN2 != '0));

    assign w_acc_next    = r_opb_mag[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mplier_next = r_opb_mag >> 1;

`ifdef SEQ_ALU_EARLY_TERM_EN
    assign w_last = (r_cnt == CW'(1)) || ((r_op == OP_MUL) && (w_mplier_next == '0));
`else
    assign w_last = (r_cnt == CW'(1));
`endif

    // During DIV/MOD the divisor magnitude sits unshifted in r_opb_mag.
    seq_alu_divstep #(
        .W (W)
    ) u_divstep (
        .i_rem     (r_rem),
        .i_divisor (r_opb_mag),
        .i_dvd_bit (r_dq[W-1]),
        .o_rem     (w_div_rem),
        .o_q       (w_q_bit)
    );

    always_comb begin
        w_sc_res = '0;
        w_sc_err = '0;
        case (OP)
            OP_ADD: begin
                w_sc_res          = sext(IN1) + sext(IN2);
                w_sc_err[ERR_OVF] = out_of_range(w_sc_res);
            end
            OP_SUB: begin
                w_sc_res          = sext(IN1) - sext(IN2);
                w_sc_err[ERR_OVF] = out_of_range(w_sc_res);
            end
            OP_MUL: begin
                w_sc_res = '0;
            end
            OP_DIV, OP_MOD: begin
                w_sc_err[ERR_DZ] = 1'b1;
            end
            default: begin
                w_sc_err = 2'b11;
            end
        endcase
    end

    always_comb begin
        w_fix_res = '0;
        w_fix_err = '0;
        case (r_op)
            OP_MUL: begin
                w_fix_res          = r_neg ? -r_acc : r_acc;
                w_fix_err[ERR_OVF] = out_of_range(w_fix_res);
            end
            OP_DIV: begin
                w_fix_res          = r_neg ? -{{W{1'b0}}, r_dq} : {{W{1'b0}}, r_dq};
                w_fix_err[ERR_OVF] = out_of_range(w_fix_res);
            end
            default: begin
                w_fix_res = r_a_neg ? -{{W{1'b0}}, r_rem} : {{W{1'b0}}, r_rem};
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        BUSY         = (r_state != S_IDLE);
        DONE         = (r_state == S_DONE);
        case (r_state)
            S_IDLE:  if (START) w_state_next = w_is_iter ? S_ITER : S_DONE;
            S_ITER:  if (w_last) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_DONE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_op      <= '0;
            r_neg     <= 1'b0;
            r_a_neg   <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_opb_mag <= '0;
            r_rem     <= '0;
            r_dq      <= '0;
            r_out     <= '0;
            r_err     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_op      <= OP;
                        r_neg     <= IN1[W-1] ^ IN2[W-1];
                        r_a_neg   <= IN1[W-1];
                        r_cnt     <= CW'(W);
                        r_acc     <= '0;
                        r_mcand   <= {{W{1'b0}}, w_a_mag};
                        r_opb_mag <= w_b_mag;
                        r_rem     <= '0;
                        r_dq      <= w_a_mag;
                        if (!w_is_iter) begin
                            r_out <= w_sc_res;
                            r_err <= w_sc_err;
                        end
                    end
                end
                S_ITER: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_op == OP_MUL) begin
                        r_acc     <= w_acc_next;
                        r_mcand   <= r_mcand << 1;
                        r_opb_mag <= w_mplier_next;
                    end else begin
                        r_rem <= w_div_rem;
                        r_dq  <= {r_dq[W-2:0], w_q_bit};
                    end
                end
                S_FIX: begin
                    r_out <= w_fix_res;
                    r_err <= w_fix_err;
                end
                default: begin
                    r_out <= r_out;
                end
            endcase
        end
    end

    assign OUT = r_out;
    assign ERR = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
//==============================================================================
// Module   : tb_seq_alu
// Desc     : Self-checking bench for seq_alu: vector table, random ops against
//            an integer model, and hand-written handshake/reset sequences.
// Revision : 1.0 - initial release
//==============================================================================
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W      = 16;
    localparam int LAT_IT = W + 2;
`ifdef SEQ_ALU_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           RST_N;
    logic           START;
    logic [3:0]     OP;
    logic [W-1:0]   IN1;
    logic [W-1:0]   IN2;
    logic           BUSY;
    logic           DONE;
    logic [2*W-1:0] OUT;
    logic [1:0]     ERR;

    typedef struct {
        logic [2*W-1:0] out;
        logic [1:0]     err;
        int             lat;
        int             acc;
    } sb_t;

    typedef struct {
        logic [3:0]     op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] out;
        logic [1:0]     err;
        int             lat;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[14];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   done_cnt = 0;

    seq_alu #(
        .W (W)
    ) dut (
        .CLK   (clk),
        .RST_N (RST_N),
        .START (START),
        .OP    (OP),
        .IN1   (IN1),
        .IN2   (IN2),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .OUT   (OUT),
        .ERR   (ERR)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int mul_lat(input logic [W-1:0] b);
        logic [W-1:0] m;
        int           steps;
        m     = b[W-1] ? -b : b;
        steps = 1;
        for (int i = 0; i < W; i++) if (m[i]) steps = i + 1;
        return EARLY ? steps + 2 : W + 2;
    endfunction

    function automatic void model(input logic [3:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [2*W-1:0] o,
                                  output logic [1:0] e, output int lat);
        longint sa, sb, r, lo, hi;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lo  = -(longint'(1) << (W - 1));
        hi  = (longint'(1) << (W - 1)) - 1;
        r   = 0;
        e   = 2'b00;
        lat = LAT_IT;
        case (op)
            OP_ADD: begin r = sa + sb; lat = 1; end
            OP_SUB: begin r = sa - sb; lat = 1; end
            OP_MUL: begin r = sa * sb; lat = mul_lat(b); end
            OP_DIV: if (sb == 0) begin e = 2'b10; lat = 1; end else r = sa / sb;
            OP_MOD: if (sb == 0) begin e = 2'b10; lat = 1; end else r = sa % sb;
            default: begin e = 2'b11; lat = 1; end
        endcase
        if (op != OP_MOD && e == 2'b00 && (r < lo || r > hi)) e[0] = 1'b1;
        o = r[2*W-1:0];
    endfunction

    // Scoreboard consumer: every DONE pulse must match the oldest expectation.
    always @(negedge clk) begin : mon
        sb_t e;
        if (DONE) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got DONE=1 expected none (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                chk("out", 64'(OUT), 64'(e.out));
                chk("err", 64'(ERR), 64'(e.err));
                chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
            end
        end
    end

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL done_timeout: got %0d pending expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] eo, input logic [1:0] ee, input int el);
        @(negedge clk);
        START = 1'b1;
        OP    = op;
        IN1   = a;
        IN2   = b;
        @(posedge clk);
        sb_q.push_back('{eo, ee, el, cyc + 1});
        @(negedge clk);
        START = 1'b0;
        wait_drain(LAT_IT + 10);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [2*W-1:0] mo;
        logic [1:0]     me;
        int             ml;
        logic [3:0]     rop;
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;
        int             sel;
        int             d0;
        int             n;

        vecs[0]  = '{OP_ADD, 16'h7FFF, 16'h0001, 32'h0000_8000, 2'b01, 1};
        vecs[1]  = '{OP_SUB, 16'hB1E0, 16'h7F1D, 32'hFFFF_32C3, 2'b01, 1};
        vecs[2]  = '{OP_MUL, 16'hFFFD, 16'h0007, 32'hFFFF_FFEB, 2'b00, mul_lat(16'h0007)};
        vecs[3]  = '{OP_MUL, 16'h8000, 16'h8000, 32'h4000_0000, 2'b01, mul_lat(16'h8000)};
        vecs[4]  = '{OP_DIV, 16'hFFF9, 16'h0002, 32'hFFFF_FFFD, 2'b00, LAT_IT};
        vecs[5]  = '{OP_MOD, 16'hFFF9, 16'h0002, 32'hFFFF_FFFF, 2'b00, LAT_IT};
        vecs[6]  = '{OP_MOD, 16'h0007, 16'hFFFE, 32'h0000_0001, 2'b00, LAT_IT};
        vecs[7]  = '{OP_DIV, 16'h0005, 16'h0000, 32'h0000_0000, 2'b10, 1};
        vecs[8]  = '{OP_DIV, 16'h8000, 16'hFFFF, 32'h0000_8000, 2'b01, LAT_IT};
        vecs[9]  = '{4'hF,   16'h1234, 16'h5678, 32'h0000_0000, 2'b11, 1};
        vecs[10] = '{OP_MOD, 16'h8000, 16'hFFFF, 32'h0000_0000, 2'b00, LAT_IT};
        vecs[11] = '{OP_MUL, 16'h7FFF, 16'hFFFF, 32'hFFFF_8001, 2'b00, mul_lat(16'hFFFF)};
        vecs[12] = '{OP_SUB, 16'h8000, 16'h0001, 32'hFFFF_7FFF, 2'b01, 1};
        vecs[13] = '{OP_MUL, 16'h0005, 16'h0000, 32'h0000_0000, 2'b00, mul_lat(16'h0000)};

        RST_N = 1'b0;
        START = 1'b0;
        OP    = '0;
        IN1   = '0;
        IN2   = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(BUSY), 64'd0);
        chk("reset_done", 64'(DONE), 64'd0);
        chk("reset_out", 64'(OUT), 64'd0);
        chk("reset_err", 64'(ERR), 64'd0);
        RST_N = 1'b1;

        // ADD handshake: BUSY for exactly the DONE cycle.
        @(negedge clk);
        START = 1'b1; OP = OP_ADD; IN1 = 16'h7FFF; IN2 = 16'h0001;
        @(posedge clk);
        sb_q.push_back('{32'h0000_8000, 2'b01, 1, cyc + 1});
        @(negedge clk);
        START = 1'b0;
        chk("busy_add", 64'(BUSY), 64'd1);
        @(negedge clk);
        chk("busy_after_add", 64'(BUSY), 64'd0);
        wait_drain(4);

        for (int i = 0; i < 14; i++)
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].out, vecs[i].err, vecs[i].lat);

        for (int i = 0; i < 24; i++) begin
            sel = int'($urandom_range(0, 6));
            rop = (sel < 5) ? 4'(sel) : 4'(sel + 5);
            ra  = W'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            model(rop, ra, rb, mo, me, ml);
            issue(rop, ra, rb, mo, me, ml);
        end

        // START held high through a MUL: one accept, one DONE.
        d0 = done_cnt;
        @(negedge clk);
        START = 1'b1; OP = OP_MUL; IN1 = 16'hFFFD; IN2 = 16'h0007;
        @(posedge clk);
        sb_q.push_back('{32'hFFFF_FFEB, 2'b00, mul_lat(16'h0007), cyc + 1});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!DONE && n < 100);
        START = 1'b0;
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL held_start_timeout: got no DONE expected DONE within 100 cycles");
        end
        repeat (2 * W) @(negedge clk);
        chk("held_start_done_count", 64'(done_cnt - d0), 64'd1);
        wait_drain(2);

        // Reset during a long MUL aborts it with no DONE.
        issue(OP_ADD, 16'h0001, 16'h0002, 32'h0000_0003, 2'b00, 1);
        @(negedge clk);
        START = 1'b1; OP = OP_MUL; IN1 = 16'hFFFD; IN2 = 16'h7FFF;
        @(posedge clk);
        @(negedge clk);
        START = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_mid_mul", 64'(BUSY), 64'd1);
        RST_N = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(BUSY), 64'd0);
        chk("abort_out", 64'(OUT), 64'd0);
        chk("abort_err", 64'(ERR), 64'd0);
        chk("abort_done", 64'(DONE), 64'd0);
        RST_N = 1'b1;
        d0 = done_cnt;
        repeat (W + 6) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);

        // Machine is usable again after the abort.
        issue(OP_DIV, 16'h0064, 16'hFFF9, 32'hFFFF_FFF2, 2'b00, LAT_IT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
